// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares one single-port data memory between the CPU MEM stage and a
// host/packet engine. At most one requester is granted per cycle. The grant
// is combinational from the current requests and the registered arbiter
// state. The granted requester drives the memory port in the same cycle.
// Read data returns one cycle later, together with a one-cycle rvalid pulse.
//
// A host that raises host_lock keeps the port for a burst. After
// MAX_HOST_BURST consecutive locked grants, a waiting CPU takes one slot.
//
// Configuration macro:
//   DMEM_ARB_RR_EN  defined   -> simultaneous requests are resolved
//                                round-robin (CPU wins from IDLE)
//                   undefined -> simultaneous requests go to the CPU
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata           CPU access request
//   host_req/we/lock/addr/wdata     host access request (lock = keep burst)
//   cpu_gnt, host_gnt               access issued this cycle
//   cpu_stall                       cpu_req and not cpu_gnt
//   cpu_rvalid/rdata                CPU read return (cycle after grant)
//   host_rvalid/rdata               host read return (cycle after grant)
//   mem_addr/din/we, mem_dout       memory port (1-cycle read latency)
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 64,
    parameter int MAX_HOST_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_lock,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              cpu_gnt,
    output logic              host_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int CNT_W = $clog2(MAX_HOST_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_HOST_BURST);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU,
        ST_HOST,
        ST_LOCK
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               cpu_rvalid_q, cpu_rvalid_d;
    logic               host_rvalid_q, host_rvalid_d;
    logic               lock_active;

    // Grant decision
    always_comb begin
        cpu_gnt     = 1'b0;
        host_gnt    = 1'b0;
        lock_active = (state_q == ST_LOCK) && host_req && host_lock;
        if (!reset) begin
            if (lock_active) begin
                // Locked burst: the host keeps the port until the burst limit.
                // At the limit, a waiting CPU takes one slot.
                if (burst_cnt_q < BURST_MAX) begin
                    host_gnt = 1'b1;
                end else if (cpu_req) begin
                    cpu_gnt = 1'b1;
                end else begin
                    host_gnt = 1'b1;
                end
            end else if (cpu_req && host_req) begin
`ifdef DMEM_ARB_RR_EN
                // The requester that was not granted last cycle wins.
                // From IDLE, HOST or LOCK, that requester is the CPU.
                if (state_q == ST_CPU) begin
                    host_gnt = 1'b1;
                end else begin
                    cpu_gnt = 1'b1;
                end
`else
                cpu_gnt = 1'b1;
`endif
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (host_req) begin
                host_gnt = 1'b1;
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Next state, burst counter and read-return tracking
    always_comb begin
        state_d       = ST_IDLE;
        burst_cnt_d   = '0;
        cpu_rvalid_d  = cpu_gnt & ~cpu_we;
        host_rvalid_d = host_gnt & ~host_we;
        if (cpu_gnt) begin
            state_d = ST_CPU;
        end else if (host_gnt) begin
            if (host_lock) begin
                state_d = ST_LOCK;
                // Saturate the counter so a long burst with no CPU waiting
                // does not wrap.
                burst_cnt_d = (burst_cnt_q < BURST_MAX) ?
                              burst_cnt_q + CNT_W'(1) : BURST_MAX;
            end else begin
                state_d = ST_HOST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            burst_cnt_q   <= '0;
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            burst_cnt_q   <= burst_cnt_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    // Mask with reset so that a read already in flight when reset arrives
    // never shows up as a valid result.
    assign cpu_rvalid  = cpu_rvalid_q & ~reset;
    assign host_rvalid = host_rvalid_q & ~reset;
    assign cpu_rdata   = mem_dout;
    assign host_rdata  = mem_dout;

    // Memory port mux. With no grant, the port is quiet (no write, address 0).
    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        if (cpu_gnt) begin
            mem_addr = cpu_addr;
            mem_din  = cpu_wdata;
            mem_we   = cpu_we;
        end else if (host_gnt) begin
            mem_addr = host_addr;
            mem_din  = host_wdata;
            mem_we   = host_we;
        end
    end

endmodule
